// File: rtl/race_starter_pkg.sv
// rtl/race_starter_pkg.sv - shared state codes for the race starter and its observer bench
package race_starter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RELEASE = 2'd2
  } race_state_e;

endpackage

// File: rtl/race_elapsed_cnt.sv
// rtl/race_elapsed_cnt.sv - elapsed-cycle counter with clear/enable and terminal compare
module race_elapsed_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term_val,
  output logic [CNT_W-1:0] cnt,
  output logic             at_term
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign at_term = (cnt_q == term_val);

endmodule

// File: rtl/race_starter.sv
// rtl/race_starter.sv - raises start on go, times the observer's done, closes the 4-phase handshake
module race_starter
  import race_starter_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000,
  parameter int REL_MAX = 8,
  parameter int RACE_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic              result_valid,
  output logic [CNT_W-1:0]  result_cycles,
  output logic              timed_out,
  output logic              proto_err,
  output logic [RACE_W-1:0] race_count
);

  localparam logic [CNT_W-1:0] RUN_TERM = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] REL_TERM = CNT_W'(REL_MAX - 1);
  localparam logic [CNT_W-1:0] TO_CYCLES = CNT_W'(TIMEOUT);

  race_state_e       state_q, state_d;
  logic              start_q, start_d;
  logic              result_valid_q, result_valid_d;
  logic [CNT_W-1:0]  result_cycles_q, result_cycles_d;
  logic              timed_out_q, timed_out_d;
  logic              proto_err_q, proto_err_d;
  logic [RACE_W-1:0] race_count_q, race_count_d;

  logic              cnt_clr, cnt_en, cnt_at_term;
  logic [CNT_W-1:0]  cnt, cnt_term;

  // One counter serves both the RUN timeout and the RELEASE window.
  race_elapsed_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .term_val (cnt_term),
    .cnt      (cnt),
    .at_term  (cnt_at_term)
  );

  always_comb begin
    state_d         = state_q;
    start_d         = start_q;
    result_valid_d  = 1'b0;
    result_cycles_d = result_cycles_q;
    timed_out_d     = timed_out_q;
    proto_err_d     = proto_err_q;
    race_count_d    = race_count_q;
    cnt_clr         = 1'b0;
    cnt_en          = 1'b0;
    cnt_term        = RUN_TERM;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          start_d     = 1'b1;
          cnt_clr     = 1'b1;
          timed_out_d = 1'b0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        start_d = 1'b1;
        // done wins over a timeout landing on the same cycle.
        if (done) begin
          result_cycles_d = cnt;
          start_d         = 1'b0;
          cnt_clr         = 1'b1;
          state_d         = ST_RELEASE;
        end else if (cnt_at_term) begin
          result_cycles_d = TO_CYCLES;
          timed_out_d     = 1'b1;
          start_d         = 1'b0;
          cnt_clr         = 1'b1;
          state_d         = ST_RELEASE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RELEASE: begin
        start_d  = 1'b0;
        cnt_term = REL_TERM;
        if (!done) begin
          result_valid_d = 1'b1;
          race_count_d   = race_count_q + RACE_W'(1);
          cnt_clr        = 1'b1;
          state_d        = ST_IDLE;
        end else if (cnt_at_term) begin
          proto_err_d    = 1'b1;
          result_valid_d = 1'b1;
          race_count_d   = race_count_q + RACE_W'(1);
          cnt_clr        = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      start_q         <= 1'b0;
      result_valid_q  <= 1'b0;
      result_cycles_q <= '0;
      timed_out_q     <= 1'b0;
      proto_err_q     <= 1'b0;
      race_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      start_q         <= start_d;
      result_valid_q  <= result_valid_d;
      result_cycles_q <= result_cycles_d;
      timed_out_q     <= timed_out_d;
      proto_err_q     <= proto_err_d;
      race_count_q    <= race_count_d;
    end
  end

  assign start         = start_q;
  assign busy          = (state_q != ST_IDLE);
  assign result_valid  = result_valid_q;
  assign result_cycles = result_cycles_q;
  assign timed_out     = timed_out_q;
  assign proto_err     = proto_err_q;
  assign race_count    = race_count_q;

endmodule

// File: tb/tb_race_starter.sv
// tb/tb_race_starter.sv - scoreboard bench for race_starter with a behavioural observer
module tb_race_starter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 16;
  localparam int REL_MAX = 8;
  localparam int RACE_W  = 2;

  localparam int OBS_NORMAL = 0;
  localparam int OBS_NEVER  = 1;
  localparam int OBS_STUCK  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              go = 1'b0;
  logic              start;
  logic              done = 1'b0;
  logic              busy;
  logic              result_valid;
  logic [CNT_W-1:0]  result_cycles;
  logic              timed_out;
  logic              proto_err;
  logic [RACE_W-1:0] race_count;

  typedef struct {
    logic [CNT_W-1:0]  cyc;
    logic              to;
    logic [RACE_W-1:0] rc;
  } exp_t;

  exp_t              sb_q[$];
  logic [RACE_W-1:0] exp_rc = '0;
  int                checks = 0;
  int                failures = 0;

  int obs_mode = OBS_NORMAL;
  int obs_d = 2;
  int obs_k = 0;

  race_starter #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .REL_MAX (REL_MAX),
    .RACE_W  (RACE_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .go            (go),
    .start         (start),
    .done          (done),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_cycles (result_cycles),
    .timed_out     (timed_out),
    .proto_err     (proto_err),
    .race_count    (race_count)
  );

  always #5 clk = ~clk;

  // Observer: done rises obs_d cycles after start is seen, falls 1 cycle after start drops.
  always @(posedge clk) begin
    if (start) begin
      if (obs_mode != OBS_NEVER) begin
        obs_k <= obs_k + 1;
        if (obs_k + 1 >= obs_d) done <= 1'b1;
      end
    end else begin
      obs_k <= 0;
      if (obs_mode != OBS_STUCK) done <= 1'b0;
    end
  end

  task automatic sb_push(input int cyc, input logic to);
    exp_t e;
    exp_rc = exp_rc + 1'b1;
    e.cyc = CNT_W'(cyc);
    e.to  = to;
    e.rc  = exp_rc;
    sb_q.push_back(e);
  endtask

  task automatic pulse_go();
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
  endtask

  // Waits (bounded) for result_valid at a negedge, then pops and compares one entry.
  task automatic sb_pop_check(input string name);
    exp_t e;
    bit   seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (result_valid) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s result_valid timeout: actual=0 required=1", name);
    end else if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected result: queue empty", name);
    end else begin
      e = sb_q.pop_front();
      if (result_cycles !== e.cyc || timed_out !== e.to || race_count !== e.rc) begin
        failures++;
        $display("FAIL %s result: actual cyc=%0d to=%0b rc=%0d required cyc=%0d to=%0b rc=%0d",
                 name, result_cycles, timed_out, race_count, e.cyc, e.to, e.rc);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (start !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0 || result_cycles !== '0 ||
        timed_out !== 1'b0 || proto_err !== 1'b0 || race_count !== '0) begin
      failures++;
      $display("FAIL reset_state: actual start=%0b busy=%0b rv=%0b cyc=%0d to=%0b pe=%0b rc=%0d required all 0",
               start, busy, result_valid, result_cycles, timed_out, proto_err, race_count);
    end
    rst = 1'b0;
    exp_rc = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int n = 0;
    obs_mode = OBS_NORMAL;
    obs_d = 2;
    sb_push(2, 1'b0);
    pulse_go();
    @(negedge clk);
    for (int i = 0; i < 50 && start; i++) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL basic_start_width: actual=%0d required=3", n);
    end
    sb_pop_check("basic");
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_pulse_once: actual rv=%0b busy=%0b required rv=0 busy=0", result_valid, busy);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    obs_mode = OBS_NEVER;
    sb_push(TIMEOUT, 1'b1);
    pulse_go();
    @(negedge clk);
    for (int i = 0; i < 100 && start; i++) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != TIMEOUT) begin
      failures++;
      $display("FAIL timeout_start_width: actual=%0d required=%0d", n, TIMEOUT);
    end
    sb_pop_check("timeout");
    checks++;
    if (proto_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_proto_err: actual=%0b required=0", proto_err);
    end
    obs_mode = OBS_NORMAL;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_go_while_busy();
    int extra = 0;
    obs_mode = OBS_NORMAL;
    obs_d = 6;
    sb_push(6, 1'b0);
    pulse_go();
    @(negedge clk);
    go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 50 && start; i++) @(negedge clk);
    go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    @(negedge clk);
    sb_pop_check("go_busy");
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (result_valid || busy) extra++;
    end
    checks++;
    if (extra != 0 || race_count !== exp_rc) begin
      failures++;
      $display("FAIL go_busy_dropped: actual extra=%0d rc=%0d required extra=0 rc=%0d", extra, race_count, exp_rc);
    end
  endtask

  task automatic test_proto_err();
    int n = 0;
    obs_mode = OBS_STUCK;
    obs_d = 2;
    sb_push(2, 1'b0);
    pulse_go();
    @(negedge clk);
    for (int i = 0; i < 50 && start; i++) @(negedge clk);
    for (int i = 0; i < 50 && busy; i++) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != REL_MAX) begin
      failures++;
      $display("FAIL proto_release_width: actual=%0d required=%0d", n, REL_MAX);
    end
    sb_pop_check("proto_race");
    checks++;
    if (proto_err !== 1'b1) begin
      failures++;
      $display("FAIL proto_err_set: actual=%0b required=1", proto_err);
    end
    obs_mode = OBS_NORMAL;
    obs_d = 3;
    repeat (2) @(negedge clk);
    sb_push(3, 1'b0);
    pulse_go();
    @(negedge clk);
    sb_pop_check("proto_good_race");
    checks++;
    if (proto_err !== 1'b1) begin
      failures++;
      $display("FAIL proto_err_sticky: actual=%0b required=1", proto_err);
    end
  endtask

  task automatic test_reset_mid_run();
    obs_mode = OBS_NORMAL;
    obs_d = 2;
    pulse_go();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (start !== 1'b0 || busy !== 1'b0 || proto_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_run: actual start=%0b busy=%0b pe=%0b required 0 0 0", start, busy, proto_err);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_rc = '0;
    repeat (3) @(negedge clk);
    sb_push(2, 1'b0);
    pulse_go();
    @(negedge clk);
    sb_pop_check("after_reset");
  endtask

  task automatic test_back_to_back();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_rc = '0;
    repeat (2) @(negedge clk);
    obs_mode = OBS_NORMAL;
    obs_d = 2;
    for (int i = 0; i < 5; i++) sb_push(2, 1'b0);
    @(posedge clk); #1 go = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      sb_pop_check("b2b");
      if (i == 4) go = 1'b0;
      @(negedge clk);
      checks++;
      if (i < 4 && (start !== 1'b1 || result_valid !== 1'b0)) begin
        failures++;
        $display("FAIL b2b_restart[%0d]: actual start=%0b rv=%0b required start=1 rv=0", i, start, result_valid);
      end else if (i == 4 && busy !== 1'b0) begin
        failures++;
        $display("FAIL b2b_stop: actual busy=%0b required=0", busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_go_while_busy();
    test_proto_err();
    test_reset_mid_run();
    test_back_to_back();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: actual=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
